moment_accum: RTL and testbench

- Parametrised successor to the fixed-width power-sum accumulators in the option-pricing regression path.
- In one batch, computes the Gram sums S_k = sum x^k for k = 0..2*DEG and the cross sums T_k = sum x^k*y for k = 0..DEG, over exactly NS samples.
- Adds a start/valid/ready handshake, a pipelined power stage, batch-complete signalling and held results.
- Feeds the matrix-inverse / solve stage, which waits for o_done.

---
 rtl/moment_accum.sv | 128 ++++++++++++
 tb/tb_moment_accum.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moment_accum.sv
// Batch power-sum accumulator: Gram sums S_k = sum x^k (k=0..2*DEG) and cross
// sums T_k = sum x^k*y (k=0..DEG) over NS samples, held for the solve stage.
module moment_accum #(
  parameter int XW  = 12,
  parameter int YW  = 16,
  parameter int DEG = 2,
  parameter int NS  = 1024,
  parameter int NSW = $clog2(NS+1),
  parameter int SXW = 2*DEG*XW+NSW,
  parameter int SYW = DEG*XW+YW+NSW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [XW-1:0]            i_x,
  input  logic [YW-1:0]            i_y,
  output logic [(2*DEG+1)*SXW-1:0] o_sx,
  output logic [(DEG+1)*SYW-1:0]   o_sxy,
  output logic [NSW-1:0]           o_count,
  output logic                     o_done,
  output logic                     o_valid
);
  localparam int PW  = 2*DEG*XW;
  localparam int XYW = DEG*XW+YW;
  localparam logic [NSW-1:0] LAST = NSW'(NS-1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e         state_q;
  logic           ready_q, done_q, valid_q, s1_vld_q;
  logic [NSW-1:0] cnt_q;
  logic           accept, clear;

  logic [2*DEG:0][PW-1:0]  pw_c, px_q;
  logic [DEG:0][XYW-1:0]   xy_c, xy_q;
  logic [2*DEG:0][SXW-1:0] sacc_q, sacc_d, sx_q;
  logic [DEG:0][SYW-1:0]   tacc_q, tacc_d, sxy_q;

  assign accept = ready_q && i_valid;
  assign clear  = i_start && (state_q == IDLE || state_q == DONE);

  // Power 0 is the constant 1, so S_0 counts samples through the same adder path.
  assign pw_c[0] = PW'(1);
  for (genvar k = 1; k <= 2*DEG; k++) begin : g_pow
    assign pw_c[k] = pw_c[k-1] * PW'(i_x);
  end
  for (genvar k = 0; k <= DEG; k++) begin : g_xy
    assign xy_c[k] = XYW'(pw_c[k]) * XYW'(i_y);
  end

  always_comb begin
    sacc_d = sacc_q;
    tacc_d = tacc_q;
    if (clear) begin
      sacc_d = '0;
      tacc_d = '0;
    end else if (s1_vld_q) begin
      for (int k = 0; k <= 2*DEG; k++) sacc_d[k] = sacc_q[k] + SXW'(px_q[k]);
      for (int k = 0; k <= DEG; k++)   tacc_d[k] = tacc_q[k] + SYW'(xy_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      px_q     <= '0;
      xy_q     <= '0;
      sacc_q   <= '0;
      tacc_q   <= '0;
      sx_q     <= '0;
      sxy_q    <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        px_q <= pw_c;
        xy_q <= xy_c;
      end
      sacc_q <= sacc_d;
      tacc_q <= tacc_d;
      sx_q   <= clear ? '0 : sacc_q;
      sxy_q  <= clear ? '0 : tacc_q;
    end
  end

  // Output copy of the accumulators lands one edge after the last add, which
  // is exactly when FLUSH sees stage 1 empty and moves to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (i_start) begin
          state_q <= RUN;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= FLUSH;
            ready_q <= 1'b0;
          end
        end
        FLUSH: if (!s1_vld_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_valid = valid_q;
  assign o_count = cnt_q;
  assign o_sx    = sx_q;
  assign o_sxy   = sxy_q;
endmodule

// File: tb/tb_moment_accum.sv
// Bench for moment_accum: three NS=4 builds (DEG 2,1,4) share one stimulus
// stream; a separate NS=1024 DEG=2 build covers the full-scale input case.
module tb_moment_accum;
  localparam int XW = 12, YW = 16;
  localparam int BS = 59, BT = 51;

  logic clk = 1'b0, rst_n = 1'b0, st_s = 1'b0, st_b = 1'b0, vld = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  always #5 clk = ~clk;

  logic [127:0] sxf [3][9];
  logic [127:0] tyf [3][5];
  logic [2:0]   donef, validf, readyf;
  logic [2:0]   cntf [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D   = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int SXW = 2*D*XW+3;
    localparam int SYW = D*XW+YW+3;
    logic [(2*D+1)*SXW-1:0] sx;
    logic [(D+1)*SYW-1:0]   sxy;
    moment_accum #(.XW(XW), .YW(YW), .DEG(D), .NS(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(st_s), .i_valid(vld), .o_ready(readyf[g]),
      .i_x(x), .i_y(y), .o_sx(sx), .o_sxy(sxy), .o_count(cntf[g]),
      .o_done(donef[g]), .o_valid(validf[g]));
    for (genvar k = 0; k < 9; k++) begin : g_sx
      if (k <= 2*D) begin : g_on
        assign sxf[g][k] = 128'(sx[k*SXW +: SXW]);
      end else begin : g_off
        assign sxf[g][k] = '0;
      end
    end
    for (genvar k = 0; k < 5; k++) begin : g_ty
      if (k <= D) begin : g_on
        assign tyf[g][k] = 128'(sxy[k*SYW +: SYW]);
      end else begin : g_off
        assign tyf[g][k] = '0;
      end
    end
  end

  logic [5*BS-1:0] sx_b;
  logic [3*BT-1:0] sxy_b;
  logic [10:0]     cnt_b;
  logic            done_b, valid_b, ready_b;
  moment_accum #(.XW(XW), .YW(YW), .DEG(2), .NS(1024)) u_big (
    .clk(clk), .rst_n(rst_n), .i_start(st_b), .i_valid(vld), .o_ready(ready_b),
    .i_x(x), .i_y(y), .o_sx(sx_b), .o_sxy(sxy_b), .o_count(cnt_b),
    .o_done(done_b), .o_valid(valid_b));

  int errs = 0, checks = 0;
  int degs [3] = '{2, 1, 4};
  logic [127:0] xq [$];
  logic [127:0] yq [$];
  logic [127:0] es [3][9];
  logic [127:0] et [3][5];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sums over the accepted-sample list with plain arithmetic.
  task automatic model();
    logic [127:0] p;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 9; k++) es[g][k] = '0;
      for (int k = 0; k < 5; k++) et[g][k] = '0;
      foreach (xq[i]) begin
        p = 128'd1;
        for (int k = 0; k <= 2*degs[g]; k++) begin
          es[g][k] += p;
          if (k <= degs[g]) et[g][k] += p * yq[i];
          p = p * xq[i];
        end
      end
    end
  endtask

  task automatic start_small();
    st_s = 1'b1;
    tick();
    st_s = 1'b0;
    xq.delete();
    yq.delete();
    chk("start_ready", 128'(readyf), 128'd7);
    chk("start_valid", 128'(validf), 128'd0);
    chk("start_cnt", 128'(cntf[0]), 128'd0);
    chk("start_S1_clr", sxf[0][1], 128'd0);
    chk("start_T0_clr", tyf[0][0], 128'd0);
  endtask

  task automatic feed(input logic [XW-1:0] xv, input logic [YW-1:0] yv, input int gap);
    vld = 1'b0;
    repeat (gap) tick();
    x = xv;
    y = yv;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    xq.push_back(128'(xv));
    yq.push_back(128'(yv));
    chk("count", 128'(cntf[0]), 128'(xq.size()));
  endtask

  task automatic check_sums();
    model();
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k <= 2*degs[g]; k++) chk($sformatf("S%0d_deg%0d", k, degs[g]), sxf[g][k], es[g][k]);
      for (int k = 0; k <= degs[g]; k++)   chk($sformatf("T%0d_deg%0d", k, degs[g]), tyf[g][k], et[g][k]);
    end
  endtask

  // Called right after the 4th acceptance edge: done must land two edges later.
  task automatic finish_small();
    tick();
    chk("done_early", 128'(donef), 128'd0);
    chk("ready_drop", 128'(readyf), 128'd0);
    tick();
    chk("done_pulse", 128'(donef), 128'd7);
    chk("valid_rise", 128'(validf), 128'd7);
    chk("final_cnt", 128'(cntf[2]), 128'd4);
    check_sums();
    tick();
    chk("done_one_cycle", 128'(donef), 128'd0);
    chk("valid_held", 128'(validf), 128'd7);
  endtask

  initial begin
    logic [127:0] p;
    logic [127:0] cs [5];
    logic [127:0] ct [3];
    cs = '{128'd4, 128'd10, 128'd30, 128'd100, 128'd354};
    ct = '{128'd4, 128'd10, 128'd30};

    tick();
    tick();
    chk("rst_ready", 128'(readyf), 128'd0);
    chk("rst_done", 128'(donef), 128'd0);
    chk("rst_valid", 128'(validf), 128'd0);
    chk("rst_cnt", 128'(cntf[0]), 128'd0);
    chk("rst_S0", sxf[0][0], 128'd0);
    chk("rst_big", 128'({ready_b, done_b, valid_b}), 128'd0);
    rst_n = 1'b1;
    tick();

    // Directed x=1..4, y=1, back to back, then again with random gaps.
    for (int pass = 0; pass < 2; pass++) begin
      start_small();
      for (int i = 1; i <= 4; i++) feed(XW'(i), YW'(1), pass == 0 ? 0 : int'($urandom_range(0, 3)));
      finish_small();
      for (int k = 0; k < 5; k++) chk($sformatf("dir_S%0d", k), sxf[0][k], cs[k]);
      for (int k = 0; k < 3; k++) chk($sformatf("dir_T%0d", k), tyf[0][k], ct[k]);
    end

    // y=2: T_k must be twice S_k in every build.
    start_small();
    for (int i = 1; i <= 4; i++) feed(XW'(i), YW'(2), 0);
    finish_small();
    chk("y2_T1_deg4", tyf[2][1], 128'd20);
    chk("y2_T4_deg4", tyf[2][4], 128'd708);

    // Random batches with gaps.
    for (int b = 0; b < 6; b++) begin
      start_small();
      for (int i = 0; i < 4; i++)
        feed(XW'($urandom_range(0, 4095)), YW'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
      finish_small();
    end

    // Start ignored in RUN/FLUSH, valid held through FLUSH/DONE.
    start_small();
    feed(12'd5, 16'd7, 0);
    st_s = 1'b1;
    feed(12'd6, 16'd8, 0);
    st_s = 1'b0;
    feed(12'd9, 16'd1, 1);
    feed(12'd4000, 16'd65000, 0);
    x = 12'd777;
    y = 16'd333;
    vld = 1'b1;
    st_s = 1'b1;
    tick();
    st_s = 1'b0;
    chk("flush_no_restart", 128'(readyf), 128'd0);
    tick();
    chk("hold_done", 128'(donef), 128'd7);
    repeat (3) tick();
    chk("hold_cnt", 128'(cntf[1]), 128'd4);
    chk("hold_valid", 128'(validf), 128'd7);
    check_sums();
    vld = 1'b0;

    // Restart from DONE clears and computes fresh sums.
    start_small();
    for (int i = 0; i < 4; i++) feed(12'd2, 16'd3, 0);
    finish_small();
    chk("restart_S2", sxf[0][2], 128'd16);
    chk("restart_T1", tyf[0][1], 128'd24);

    // Reset mid-batch discards samples.
    start_small();
    feed(12'd4095, 16'd65535, 0);
    feed(12'd3000, 16'd1234, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", 128'(readyf), 128'd0);
    chk("mid_rst_cnt", 128'(cntf[0]), 128'd0);
    chk("mid_rst_valid", 128'(validf), 128'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("mid_rst_S%0d", k), sxf[0][k], 128'd0);
    tick();
    tick();
    chk("mid_rst_no_done", 128'(donef), 128'd0);
    start_small();
    for (int i = 0; i < 4; i++)
      feed(XW'($urandom_range(0, 4095)), YW'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
    finish_small();

    // Full-scale inputs over 1024 samples.
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    chk("big_ready", 128'(ready_b), 128'd1);
    x = 12'd4095;
    y = 16'd65535;
    vld = 1'b1;
    repeat (1024) tick();
    vld = 1'b0;
    chk("big_cnt", 128'(cnt_b), 128'd1024);
    tick();
    chk("big_done_early", 128'(done_b), 128'd0);
    tick();
    chk("big_done", 128'(done_b), 128'd1);
    chk("big_valid", 128'(valid_b), 128'd1);
    p = 128'd1024;
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("big_S%0d", k), 128'(sx_b[k*BS +: BS]), p);
      if (k <= 2) chk($sformatf("big_T%0d", k), 128'(sxy_b[k*BT +: BT]), p * 128'd65535);
      p = p * 128'd4095;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
